// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, fixed access
// latency, per-byte store enables and misaligned/out-of-range error flagging.

module dmem_lane_merge (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module dmem_responder #(
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DWIDTH-1:0]     req_addr,
  input  logic [DWIDTH-1:0]     req_wdata,
  input  logic [DWIDTH/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DWIDTH-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);
  localparam int LANES = DWIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // One extra bit so DEPTH*4 is representable even when it equals 2**DWIDTH.
  localparam logic [DWIDTH:0] LIMIT = (DWIDTH+1)'(DEPTH) << 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic                    lat_we;
  logic [DWIDTH-1:0]       lat_addr;
  logic [DWIDTH-1:0]       lat_wdata;
  logic [LANES-1:0]        lat_be;

  logic [DWIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]           idx;
  logic                    acc_err;
  logic                    access;
  logic [LANES-1:0][7:0]   old_word;
  logic [LANES-1:0][7:0]   new_word;

  assign idx       = lat_addr[AW+1:2];
  assign acc_err   = (lat_addr[1:0] != 2'b00) || ({1'b0, lat_addr} >= LIMIT);
  assign access    = (state == WAIT) && (cnt == '0);
  assign old_word  = mem[idx];
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dmem_lane_merge u_lane (
      .old_byte (old_word[g]),
      .new_byte (lat_wdata[8*g +: 8]),
      .en       (lat_be[g]),
      .merged   (new_word[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_we    <= req_we;
          lat_addr  <= req_addr;
          lat_wdata <= req_wdata;
          lat_be    <= req_be;
          cnt       <= CW'(LATENCY - 1);
          state     <= WAIT;
        end
        WAIT: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          resp_rdata <= (acc_err || lat_we) ? '0 : mem[idx];
          resp_err   <= acc_err;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; a store whose access edge sees rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && access && !acc_err && lat_we)
      mem[idx] <= new_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a word-array reference model.

module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_1, resp_ready_1, req_ready_1, resp_valid_1, resp_err_1, busy_1;
  logic [31:0] resp_rdata_1;
  logic        req_valid_3, resp_ready_3, req_ready_3, resp_valid_3, resp_err_3, busy_3;
  logic [31:0] resp_rdata_3;

  logic        sel;
  logic        s_req_ready, s_resp_valid, s_resp_err;
  logic [31:0] s_resp_rdata;
  assign s_req_ready  = sel ? req_ready_3  : req_ready_1;
  assign s_resp_valid = sel ? resp_valid_3 : resp_valid_1;
  assign s_resp_err   = sel ? resp_err_3   : resp_err_1;
  assign s_resp_rdata = sel ? resp_rdata_3 : resp_rdata_1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  dmem_responder #(.DWIDTH(32), .DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy));

  dmem_responder #(.DWIDTH(32), .DEPTH(256), .LATENCY(1)) u_s1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_rdata(resp_rdata_1),
    .resp_err(resp_err_1), .busy(busy_1));

  dmem_responder #(.DWIDTH(32), .DEPTH(256), .LATENCY(3)) u_s3 (
    .clk(clk), .rst(rst), .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid_3), .resp_ready(resp_ready_3), .resp_rdata(resp_rdata_3),
    .resp_err(resp_err_3), .busy(busy_3));

  function automatic logic is_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic ref_main(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] ed, output logic ee);
    ed = 32'h0;
    ee = is_err(a);
    if (!ee && we) ref_mem[a / 4] = merge(ref_mem[a / 4], d, be);
    else if (!ee) ed = ref_mem[a / 4];
  endtask

  // Drives one full transaction on the LATENCY=2 instance; lat counts cycles
  // from acceptance until resp_valid is first seen.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; resp_ready = 0;
    req_valid_1 = 0; resp_ready_1 = 0; req_valid_3 = 0; resp_ready_3 = 0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", resp_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (busy_1 !== 1'b0 || busy_3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_stream got %b%b want 00", busy_1, busy_3); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd, ed; logic er, ee; int lat;
    ref_main(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ed, ee);
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    n_cmp += 3;
    if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", lat); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", er); end
    if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata got %h want 0", rd); end
    ref_main(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp += 3;
    if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got %0d want 2", lat); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b want 0", er); end
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_enables;
    logic [31:0] rd, ed; logic er, ee; int lat;
    ref_main(1'b1, 32'h10, 32'h11223344, 4'b0101, ed, ee);
    do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
    ref_main(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_cmp += 2;
    if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_merge got %h want de22be44", rd); end
    if (rd !== ed) begin n_fail++; $display("FAIL be_model got %h want %h", rd, ed); end
    // be = 0 store: response still produced, memory untouched
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL be_zero_resp got lat %0d err %b want 2 0", lat, er); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_zero_mem got %h want de22be44", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, ed; logic er, ee; int lat;
    ref_main(1'b1, 32'h0, 32'h600DF00D, 4'hF, ed, ee);
    do_req(1'b1, 32'h0, 32'h600DF00D, 4'hF, rd, er, lat);
    do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    n_cmp += 2;
    if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b want 1", er); end
    if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata got %h want 0", rd); end
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL range_err got %b want 1", er); end
    do_req(1'b1, 32'hFFFFFC00, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL range_high_err got %b want 1", er); end
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_err got %b want 0", er); end
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h600DF00D) begin n_fail++; $display("FAIL no_alias got %h want 600df00d", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d0, rd, ed; logic e0, er, ee; int lat;
    ref_main(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    d0 = resp_rdata; e0 = resp_err;
    n_cmp += 2;
    if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got %0d want 2", lat); end
    if (d0 !== ed || e0 !== ee) begin n_fail++; $display("FAIL bp_data got %h/%b want %h/%b", d0, e0, ed, ee); end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_be = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== d0 || resp_err !== e0 || req_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold cyc %0d got v%b d%h e%b r%b want v1 d%h e%b r0",
          c, resp_valid, resp_rdata, resp_err, req_ready, d0, e0); end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_release got v%b b%b r%b want v0 b0 r1", resp_valid, busy, req_ready); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== ed) begin n_fail++; $display("FAIL bp_ignored_req got %h want %h", rd, ed); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd, ed; logic er, ee, seen; int lat;
    ref_main(1'b1, 32'h20, 32'h0A0A0A0A, 4'hF, ed, ee);
    do_req(1'b1, 32'h20, 32'h0A0A0A0A, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55555555; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstw_busy_before got %b want 1", busy); end
    // rst held across both the next edge and the would-be access edge
    rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); seen |= resp_valid; end
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy_after got %b want 0", busy); end
    repeat (5) begin @(negedge clk); seen |= resp_valid; end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rstw_no_resp got %b want 0", seen); end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0A0A0A0A) begin n_fail++; $display("FAIL rstw_mem got %h want 0a0a0a0a", rd); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, rd, ed; logic [3:0] be; logic we, er, ee; int lat, r;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      ref_main(1'b1, 32'(w * 4), d, 4'hF, ed, ee);
      do_req(1'b1, 32'(w * 4), d, 4'hF, rd, er, lat);
    end
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 4000) * 4);
      else             a = 32'($urandom_range(0, 15) * 4);
      we = 1'($urandom); d = $urandom; be = 4'($urandom);
      ref_main(we, a, d, be, ed, ee);
      do_req(we, a, d, be, rd, er, lat);
      n_cmp += 3;
      if (lat !== 2) begin n_fail++; $display("FAIL rand_latency #%0d got %0d want 2", k, lat); end
      if (er !== ee) begin n_fail++; $display("FAIL rand_err #%0d addr %h got %b want %b", k, a, er, ee); end
      if (rd !== ed) begin n_fail++; $display("FAIL rand_rdata #%0d addr %h got %h want %h", k, a, rd, ed); end
    end
  endtask

  // Acceptance at edge N, access at N+L, handshake at N+L+1 (resp_ready held
  // high), next acceptance at N+L+2.
  task automatic test_streaming(input int lat);
    logic [31:0] m [16];
    logic [31:0] q_d [$];
    logic        q_e [$];
    logic [31:0] a, d, ed; logic [3:0] be; logic we, ee;
    int issued, last_acc, r, cyc;
    issued = 0; last_acc = -1;
    sel = (lat == 3);
    @(negedge clk);
    if (lat == 3) resp_ready_3 = 1'b1; else resp_ready_1 = 1'b1;
    for (cyc = 0; cyc < 600 && !(issued == 30 && q_d.size() == 0); cyc++) begin
      @(negedge clk);
      if (s_resp_valid) begin
        n_cmp++;
        if (q_d.size() == 0) begin
          n_fail++; $display("FAIL stream%0d_extra_resp got %h", lat, s_resp_rdata);
        end else begin
          if (s_resp_rdata !== q_d[0] || s_resp_err !== q_e[0]) begin
            n_fail++; $display("FAIL stream%0d_resp got %h/%b want %h/%b",
              lat, s_resp_rdata, s_resp_err, q_d[0], q_e[0]);
          end
          void'(q_d.pop_front()); void'(q_e.pop_front());
        end
      end
      if (s_req_ready && issued < 30) begin
        if (issued < 16) begin
          a = 32'(issued * 4); we = 1'b1; be = 4'hF;
        end else begin
          r = $urandom_range(0, 9);
          if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
          else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 200) * 4);
          else             a = 32'($urandom_range(0, 15) * 4);
          we = 1'($urandom); be = 4'($urandom);
        end
        d = $urandom;
        req_we = we; req_addr = a; req_wdata = d; req_be = be;
        if (lat == 3) req_valid_3 = 1'b1; else req_valid_1 = 1'b1;
        ee = is_err(a); ed = 32'h0;
        if (!ee && we) m[a / 4] = merge(m[a / 4], d, be);
        else if (!ee) ed = m[a / 4];
        q_d.push_back(ed); q_e.push_back(ee);
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== lat + 2) begin
            n_fail++; $display("FAIL stream%0d_interval got %0d want %0d", lat, cyc - last_acc, lat + 2);
          end
        end
        last_acc = cyc;
        issued++;
      end else if (issued == 30) begin
        req_valid_1 = 1'b0; req_valid_3 = 1'b0;
      end
    end
    n_cmp++;
    if (issued != 30 || q_d.size() != 0) begin
      n_fail++; $display("FAIL stream%0d_timeout issued %0d pending %0d want 30 0", lat, issued, q_d.size());
    end
    req_valid_1 = 1'b0; req_valid_3 = 1'b0; resp_ready_1 = 1'b0; resp_ready_3 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_enables;
    test_errors;
    test_backpressure;
    test_reset_in_wait;
    test_random;
    test_streaming(1);
    test_streaming(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
